// File: rtl/uart_boot_loader_if.sv
// UART RX FIFO read port and instruction-memory write port seen by the boot loader.
// master = boot loader side, slave = FIFO / instruction memory side.
interface uart_boot_loader_if;
  logic        uart_empty;
  logic [7:0]  uart_in;
  logic        uart_rdreq;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    input  uart_empty,
    input  uart_in,
    output uart_rdreq,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output uart_empty,
    output uart_in,
    input  uart_rdreq,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Boot sequencer: pulls a length-prefixed, XOR-checksummed image from the UART RX FIFO,
// writes it into instruction memory and releases the core only when the checksum matches.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  uart_boot_loader_if.master bus,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state, state_nxt;
  logic        pending;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_bytes;
  logic [15:0] len;
  logic [7:0]  csum;
  logic        fetch_ok;
  logic        start_ok;
  logic [15:0] hdr_len;
  logic        hdr_too_big;

  assign hdr_len     = {bus.uart_in, len[7:0]};
  assign hdr_too_big = {1'b0, hdr_len} > MAX_LEN;
  assign start_ok    = start && (state == IDLE || state == DONE || state == ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // DATA stays put for the cycle of the final write so imem_we is never seen outside DATA.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    fetch_ok  = 1'b0;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = LEN;
      LEN: begin
        busy     = 1'b1;
        fetch_ok = 1'b1;
        if (pending && byte_cnt[0]) begin
          if (hdr_len == 16'd0) state_nxt = DONE;
          else if (hdr_too_big) state_nxt = ERROR;
          else                  state_nxt = DATA;
        end
      end
      DATA: begin
        busy     = 1'b1;
        fetch_ok = (words_loaded != len);
        if (words_loaded == len) state_nxt = CSUM;
      end
      CSUM: begin
        busy     = 1'b1;
        fetch_ok = 1'b1;
        if (pending) state_nxt = (bus.uart_in == csum) ? DONE : ERROR;
      end
      default: state_nxt = IDLE;
    endcase
    bus.uart_rdreq = fetch_ok && !pending && !bus.uart_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending        <= 1'b0;
      byte_cnt       <= '0;
      asm_bytes      <= '0;
      len            <= '0;
      csum           <= '0;
      cpu_run        <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      pending     <= bus.uart_rdreq;
      bus.imem_we <= 1'b0;
      if (start_ok) begin
        cpu_run      <= 1'b0;
        error        <= 1'b0;
        words_loaded <= '0;
        csum         <= '0;
        byte_cnt     <= '0;
      end
      case (state)
        LEN: if (pending) begin
          if (!byte_cnt[0]) begin
            len[7:0] <= bus.uart_in;
            byte_cnt <= 2'd1;
          end else begin
            len[15:8] <= bus.uart_in;
            byte_cnt  <= '0;
            if (hdr_len == 16'd0) cpu_run <= 1'b1;
            else if (hdr_too_big) error <= 1'b1;
          end
        end
        DATA: if (pending) begin
          csum      <= csum ^ bus.uart_in;
          byte_cnt  <= byte_cnt + 2'd1;
          asm_bytes <= {bus.uart_in, asm_bytes[23:8]};
          if (byte_cnt == 2'd3) begin
            bus.imem_we    <= 1'b1;
            bus.imem_wdata <= {bus.uart_in, asm_bytes};
            bus.imem_addr  <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
            words_loaded   <= words_loaded + 16'd1;
          end
        end
        CSUM: if (pending) begin
          if (bus.uart_in == csum) cpu_run <= 1'b1;
          else                     error   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
